// File: rtl/df_multiplier_seq_pkg.sv
// df_multiplier_seq_pkg: shared FSM state encoding for the filter multiplier blocks
package df_multiplier_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/df_multiplier_seq_if.sv
// df_multiplier_seq_if: sample/result handshakes plus coefficient register access
// master: drives in_valid/in_data, out_ready, coef_we/coef_in; slave: the multiplier
interface df_multiplier_seq_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 5,
  parameter int OUT_W  = 8
);
  logic              coef_we;
  logic [COEF_W-1:0] coef_in;
  logic [COEF_W-1:0] coef;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;
  modport master (
    output coef_we, coef_in, in_valid, in_data, out_ready,
    input  coef, in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  coef_we, coef_in, in_valid, in_data, out_ready,
    output coef, in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/df_round_sat.sv
// df_round_sat: optional round-half-up, right shift by SHIFT and unsigned saturation to OUT_W
// acc: full-width product in; data: reduced result; sat: result was clipped
module df_round_sat #(
  parameter int P     = 13,
  parameter int SHIFT = 8,
  parameter int ROUND = 0,
  parameter int OUT_W = 8
) (
  input  logic [P-1:0]     acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);
  localparam logic [P:0] RND = (ROUND != 0 && SHIFT > 0) ? {{P{1'b0}}, 1'b1} << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  logic [P:0] sum;
  logic [P:0] shifted;
  // one extra bit so the rounding add cannot wrap
  assign sum = {1'b0, acc} + RND;
  assign shifted = sum >> SHIFT;
  assign sat = (shifted >> OUT_W) != '0;
  assign data = sat ? '1 : OUT_W'(shifted);
endmodule

// File: rtl/df_multiplier_seq.sv
// df_multiplier_seq: shift-add multiplier computing sat((data*coef + rnd) >> SHIFT) with a run-time coefficient
// clk/rst: clock and async active-high reset; bus: sample/result handshakes and coefficient access; busy: not idle
module df_multiplier_seq
  import df_multiplier_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 5,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 8,
  parameter int ROUND      = 0,
  parameter int COEF_RESET = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  df_multiplier_seq_if.slave   bus,
  output logic                 busy
);
  localparam int P  = DATA_W + COEF_W;
  localparam int CW = $clog2(COEF_W + 1);
  state_t            state, state_n;
  logic [P-1:0]      mcand, acc;
  logic [COEF_W-1:0] mult, coef_r;
  logic [CW-1:0]     cnt;
  logic [OUT_W-1:0]  out_data_r, rs_data;
  logic              out_sat_r, rs_sat, run_done;
  // RUN steps while cnt < COEF_W and leaves once all multiplier bits are consumed
  assign run_done = cnt == CW'(COEF_W);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
              state == RUN  ? (run_done ? FIN : RUN) :
              state == FIN  ? DONE :
              (bus.out_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
    busy          = state != IDLE;
  end
  df_round_sat #(.P(P), .SHIFT(SHIFT), .ROUND(ROUND), .OUT_W(OUT_W)) u_rs (
    .acc  (acc),
    .data (rs_data),
    .sat  (rs_sat)
  );
  // the multiplier snapshot is taken before a same-edge coefficient write lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      coef_r     <= COEF_W'(COEF_RESET);
      mcand      <= '0;
      mult       <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_data_r <= '0;
      out_sat_r  <= 1'b0;
    end else begin
      if (bus.coef_we) coef_r <= bus.coef_in;
      if (state == IDLE && bus.in_valid) begin
        mcand <= P'(bus.in_data);
        mult  <= coef_r;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN && !run_done) begin
        acc   <= acc + (mult[0] ? mcand : '0);
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt + 1'b1;
      end
      if (state == FIN) begin
        out_data_r <= rs_data;
        out_sat_r  <= rs_sat;
      end
    end
  assign bus.coef     = coef_r;
  assign bus.out_data = out_data_r;
  assign bus.out_sat  = out_sat_r;
endmodule

// File: tb/tb_df_multiplier_seq.sv
// tb_df_multiplier_seq: scoreboard bench for three multiplier variants (default, rounding, 4-bit output)
module tb_df_multiplier_seq;
  typedef struct {
    logic [7:0] data;
    logic       sat;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv, ordy, cwe, irdy, ov, osat, bsy;
  logic [7:0] id[3];
  logic [4:0] cin[3];
  logic [7:0] od[3];
  logic [4:0] cf[3];
  exp_t       sb[3][$];
  int         mcoef[3];
  int         npass = 0;
  int         ntot = 0;
  always #5 clk = ~clk;
  df_multiplier_seq_if #(.OUT_W(8)) b0();
  df_multiplier_seq_if #(.OUT_W(8)) b1();
  df_multiplier_seq_if #(.OUT_W(4)) b2();
  df_multiplier_seq u0 (.clk(clk), .rst(rst), .bus(b0), .busy(bsy[0]));
  df_multiplier_seq #(.ROUND(1)) u1 (.clk(clk), .rst(rst), .bus(b1), .busy(bsy[1]));
  df_multiplier_seq #(.OUT_W(4)) u2 (.clk(clk), .rst(rst), .bus(b2), .busy(bsy[2]));
  assign b0.in_valid = iv[0];
  assign b1.in_valid = iv[1];
  assign b2.in_valid = iv[2];
  assign b0.in_data = id[0];
  assign b1.in_data = id[1];
  assign b2.in_data = id[2];
  assign b0.out_ready = ordy[0];
  assign b1.out_ready = ordy[1];
  assign b2.out_ready = ordy[2];
  assign b0.coef_we = cwe[0];
  assign b1.coef_we = cwe[1];
  assign b2.coef_we = cwe[2];
  assign b0.coef_in = cin[0];
  assign b1.coef_in = cin[1];
  assign b2.coef_in = cin[2];
  assign irdy = {b2.in_ready, b1.in_ready, b0.in_ready};
  assign ov = {b2.out_valid, b1.out_valid, b0.out_valid};
  assign osat = {b2.out_sat, b1.out_sat, b0.out_sat};
  assign od[0] = b0.out_data;
  assign od[1] = b1.out_data;
  assign od[2] = {4'b0, b2.out_data};
  assign cf[0] = b0.coef;
  assign cf[1] = b1.coef;
  assign cf[2] = b2.coef;
  function automatic exp_t model(int data, int c, bit rnd, int ow);
    exp_t e;
    int s;
    s = (data * c + (rnd ? 128 : 0)) >> 8;
    e.sat = s >= (1 << ow);
    e.data = e.sat ? 8'((1 << ow) - 1) : 8'(s);
    return e;
  endfunction
  task automatic accept(int d, int data, bit we = 1'b0, int wv = 0);
    int n = 0;
    while (!irdy[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ntot++;
    if (irdy[d] !== 1'b1) $display("FAIL accept%0d in_ready got %b want 1", d, irdy[d]);
    else npass++;
    iv[d] = 1'b1;
    id[d] = 8'(data);
    cwe[d] = we;
    cin[d] = 5'(wv);
    sb[d].push_back(model(data, mcoef[d], d == 1, d == 2 ? 4 : 8));
    if (we) mcoef[d] = wv;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    cwe[d] = 1'b0;
  endtask
  task automatic collect(int d, int lat, string tag);
    int n = 0;
    exp_t e;
    while (!ov[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ntot++;
    if (!ov[d] || (lat > 0 && n != lat)) $display("FAIL %s latency got %0d edges (valid=%b) want %0d", tag, n, ov[d], lat);
    else npass++;
    e = sb[d].size() > 0 ? sb[d].pop_front() : '{8'hxx, 1'bx};
    ntot++;
    if (od[d] !== e.data) $display("FAIL %s out_data got %0d want %0d", tag, od[d], e.data);
    else npass++;
    ntot++;
    if (osat[d] !== e.sat) $display("FAIL %s out_sat got %b want %b", tag, osat[d], e.sat);
    else npass++;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ntot++;
    if (ov[d] !== 1'b0 || irdy[d] !== 1'b1) $display("FAIL %s after transfer valid=%b ready=%b want 0/1", tag, ov[d], irdy[d]);
    else npass++;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      ntot++;
      if (cf[d] !== 5'd27) $display("FAIL reset%0d coef got %0d want 27", d, cf[d]);
      else npass++;
    end
    ntot++;
    if (irdy !== 3'b111) $display("FAIL reset in_ready got %b want 111", irdy);
    else npass++;
    ntot++;
    if (ov !== 3'b000 || osat !== 3'b000 || bsy !== 3'b000) $display("FAIL reset valid/sat/busy got %b/%b/%b want 0", ov, osat, bsy);
    else npass++;
    ntot++;
    if (od[0] !== 8'd0) $display("FAIL reset out_data got %0d want 0", od[0]);
    else npass++;
  endtask
  task automatic test_basic();
    accept(0, 200);
    collect(0, 7, "basic_200");
    accept(0, 7);
    collect(0, 7, "basic_7");
  endtask
  task automatic test_round();
    accept(1, 255);
    collect(1, 7, "round_on");
    accept(0, 255);
    collect(0, 7, "round_off");
  endtask
  task automatic test_sat();
    cwe[2] = 1'b1;
    cin[2] = 5'd31;
    @(posedge clk); #1;
    cwe[2] = 1'b0;
    mcoef[2] = 31;
    ntot++;
    if (cf[2] !== 5'd31) $display("FAIL sat coef write got %0d want 31", cf[2]);
    else npass++;
    accept(2, 255);
    collect(2, 7, "sat_clip");
    accept(2, 16);
    collect(2, 7, "sat_noclip");
  endtask
  task automatic test_backpressure();
    int n = 0;
    ordy[0] = 1'b0;
    accept(0, 123);
    while (!ov[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      ntot++;
      if (ov[0] !== 1'b1 || irdy[0] !== 1'b0 || sb[0].size() == 0 || od[0] !== sb[0][0].data || osat[0] !== sb[0][0].sat)
        $display("FAIL backpressure cycle %0d valid=%b ready=%b data=%0d sat=%b", i, ov[0], irdy[0], od[0], osat[0]);
      else npass++;
      @(posedge clk); #1;
    end
    collect(0, 0, "backpressure");
  endtask
  task automatic test_coef();
    accept(0, 100, 1'b1, 3);
    collect(0, 7, "coef_same_edge");
    accept(0, 100);
    collect(0, 7, "coef_new");
    accept(0, 200);
    @(posedge clk); #1;
    cwe[0] = 1'b1;
    cin[0] = 5'd31;
    @(posedge clk); #1;
    cwe[0] = 1'b0;
    mcoef[0] = 31;
    collect(0, 0, "coef_mid_run");
    ntot++;
    if (cf[0] !== 5'd31) $display("FAIL coef_mid_run register got %0d want 31", cf[0]);
    else npass++;
  endtask
  task automatic test_reset_mid();
    accept(0, 200);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    ntot++;
    if (bsy[0] !== 1'b0 || ov[0] !== 1'b0 || irdy[0] !== 1'b1 || cf[0] !== 5'd27)
      $display("FAIL reset_mid busy=%b valid=%b ready=%b coef=%0d want 0/0/1/27", bsy[0], ov[0], irdy[0], cf[0]);
    else npass++;
    void'(sb[0].pop_back());
    for (int d = 0; d < 3; d++) mcoef[d] = 27;
    @(posedge clk); #1;
    rst = 1'b0;
    accept(0, 150);
    collect(0, 7, "after_reset");
  endtask
  initial begin
    rst = 1'b1;
    iv = '0;
    cwe = '0;
    ordy = '1;
    for (int d = 0; d < 3; d++) begin
      id[d] = '0;
      cin[d] = '0;
      mcoef[d] = 27;
    end
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_backpressure();
    test_coef();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
